// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Results are registered and returned to the winning requester through a valid/ready response.
module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [2*DATA_WIDTH-1:0]      req_a,
    input  logic [2*DATA_WIDTH-1:0]      req_b,
    input  logic [2*OPCODE_LENGTH-1:0]   req_op,
    output logic [1:0]                   rsp_valid,
    input  logic [1:0]                   rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_result,
    output logic                         rsp_zero,
    output logic                         busy,
    output logic [DATA_WIDTH-1:0]        alu_srca,
    output logic [DATA_WIDTH-1:0]        alu_srcb,
    output logic [OPCODE_LENGTH-1:0]     alu_op,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    input  logic                         alu_zero
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    prio, prio_nxt;
    logic                    owner, owner_nxt;
    logic [DATA_WIDTH-1:0]   result_nxt;
    logic                    zero_nxt;
    logic                    can_issue;
    logic                    grant;
    logic                    gidx;
    logic                    upper_zero;
    logic                    is_compare;

    // Compare opcodes are 1010..1111; wider opcode fields must have zero upper bits to qualify.
    if (OPCODE_LENGTH > 4) begin : g_wide_op
        assign upper_zero = ~|alu_op[OPCODE_LENGTH-1:4];
    end else begin : g_narrow_op
        assign upper_zero = 1'b1;
    end

    assign is_compare = upper_zero & alu_op[3] & (alu_op[2] | alu_op[1]);

    // Grant is suppressed while reset is held so req_ready and the ALU operands stay at zero.
    always_comb begin
        can_issue = (state == IDLE) || rsp_ready[owner];
        grant     = 1'b0;
        gidx      = 1'b0;
        if (rst_n && can_issue) begin
            if (req_valid == 2'b11) begin
                grant = 1'b1;
                gidx  = prio;
            end else if (req_valid[0]) begin
                grant = 1'b1;
                gidx  = 1'b0;
            end else if (req_valid[1]) begin
                grant = 1'b1;
                gidx  = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = 2'b00;
        alu_srca  = '0;
        alu_srcb  = '0;
        alu_op    = '0;
        if (grant) begin
            req_ready = gidx ? 2'b10 : 2'b01;
            alu_srca  = gidx ? req_a[DATA_WIDTH +: DATA_WIDTH] : req_a[0 +: DATA_WIDTH];
            alu_srcb  = gidx ? req_b[DATA_WIDTH +: DATA_WIDTH] : req_b[0 +: DATA_WIDTH];
            alu_op    = gidx ? req_op[OPCODE_LENGTH +: OPCODE_LENGTH]
                             : req_op[0 +: OPCODE_LENGTH];
        end
    end

    // A new grant overwrites the held response in the same edge the old one is accepted.
    always_comb begin
        state_nxt  = state;
        prio_nxt   = prio;
        owner_nxt  = owner;
        result_nxt = rsp_result;
        zero_nxt   = rsp_zero;
        if (grant) begin
            result_nxt = alu_result;
            zero_nxt   = is_compare ? alu_zero : (alu_result == '0);
            owner_nxt  = gidx;
            prio_nxt   = ~gidx;
            state_nxt  = RESP;
        end else if ((state == RESP) && rsp_ready[owner]) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state      <= state_nxt;
            prio       <= prio_nxt;
            owner      <= owner_nxt;
            rsp_result <= result_nxt;
            rsp_zero   <= zero_nxt;
        end
    end

    assign busy      = (state == RESP);
    assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters, for example the execute stage and a branch/address helper. The block applies round-robin arbitration and issues one operation per cycle. It registers the ALU result and returns it to the winning requester through a valid/ready response. It also normalises the `zero` flag, because the ALU only defines `zero` for compare opcodes.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width.
- `OPCODE_LENGTH`, 4, ALU operation code width.

Ports (requester i uses slice `[i*W +: W]` of packed buses):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  2  requester i has an operation.
- `req_ready`  out  2  requester i granted this cycle; at most one bit high.
- `req_a`  in  2*DATA_WIDTH  operand A per requester.
- `req_b`  in  2*DATA_WIDTH  operand B per requester.
- `req_op`  in  2*OPCODE_LENGTH  ALU opcode per requester.
- `rsp_valid`  out  2  result pending for requester i; at most one bit high.
- `rsp_ready`  in  2  requester i accepts the result.
- `rsp_result`  out  DATA_WIDTH  registered ALU result.
- `rsp_zero`  out  1  registered, normalised zero flag.
- `busy`  out  1  a response is pending (state RESP).
- `alu_srca`  out  DATA_WIDTH  to ALU `SrcA`.
- `alu_srcb`  out  DATA_WIDTH  to ALU `SrcB`.
- `alu_op`  out  OPCODE_LENGTH  to ALU `Operation`.
- `alu_result`  in  DATA_WIDTH  from ALU `ALUResult`.
- `alu_zero`  in  1  from ALU `zero`.

## Operation
- States:
  - IDLE: no pending response.
  - RESP: one response held in `rsp_result`/`rsp_zero`, owned by requester `owner`.
- `can_issue` = (state == IDLE) or (RESP and `rsp_ready[owner]`).
- Arbitration, evaluated only when `can_issue`:
  - Only one `req_valid` bit set: grant that requester.
  - Both bits set: grant `prio`.
  - After any grant, `prio` = index of the non-granted requester.
- `req_ready[g]` = grant, combinational. It may depend on `req_valid`. A requester must not make its `req_valid` depend on `req_ready`.
- While a grant is active, `alu_srca`/`alu_srcb`/`alu_op` = granted requester's operands/opcode, combinational. With no grant they are all zero (opcode 0000 = AND, harmless).
- Actions on a clock edge with a grant:
  - `rsp_result` <= `alu_result`.
  - `owner` <= g.
  - state <= RESP.
  - `rsp_zero` <= `alu_zero` if the opcode is in 1010–1111. Otherwise `rsp_zero` <= (`alu_result` == 0).
- No grant, RESP, and `rsp_ready[owner]`: state <= IDLE.
- RESP without `rsp_ready[owner]`:
  - Hold `rsp_result`, `rsp_zero` and `owner`.
  - `req_ready` = 00.
  - `prio` is unchanged.
- `rsp_valid[i]` = (state == RESP) and (`owner` == i).
- `busy` = (state == RESP).
- Opcodes 1000/1001 are issued normally; the ALU returns 0, so `rsp_zero` = 1. The arbiter performs no opcode checking beyond the zero rule.

## Timing
- Reset values while `rst_n` = 0, effective immediately and asynchronously:
  - state = IDLE, `prio` = 0, `owner` = 0.
  - `rsp_valid` = 00, `rsp_result` = 0, `rsp_zero` = 0, `busy` = 0.
  - `req_ready` = 00.
  - `alu_*` outputs = 0.
- Latency: request granted in cycle N; `rsp_valid` high in cycle N+1.
- Throughput: one operation per cycle when the owner holds `rsp_ready` high. Response accept and new grant happen in the same cycle, with no bubble.
- Back-to-back ownership change: a new owner's response replaces the old one at the same edge the old one is accepted.
- Reset mid-operation: a pending response is discarded without a handshake. The first grant after `rst_n` rises goes to requester 0 if both are valid.
- `req_*` inputs are sampled only in the cycle where `req_ready` is high. They may change freely otherwise.
- `rsp_ready` of the non-owner is ignored.

## Test plan
- Reset, then requester 0 issues ADD (0010) a=5, b=7 with `rsp_ready` = 11:
  - `req_ready` = 01 in cycle 0.
  - Cycle 1: `rsp_valid` = 01, `rsp_result` = 12, `rsp_zero` = 0.
- Requester 1 issues SUB (0110) a=3, b=3 → `rsp_valid` = 10, `rsp_result` = 0, `rsp_zero` = 1 (from the result, not `alu_zero`).
- Requester 0 issues signed-less-than (1011) a=0xFFFFFFFF, b=1 → `rsp_result` = 1, `rsp_zero` = `alu_zero` = 1.
- Both requesters continuously valid, `rsp_ready` = 11 → grants alternate 0,1,0,1 starting with 0; a result every cycle; `busy` stays 1.
- Backpressure: owner 0 holds `rsp_ready[0]` = 0 for 3 cycles while requester 1 is valid:
  - `req_ready` = 00 and `rsp_result` is stable for those cycles.
  - In the cycle `rsp_ready[0]` rises, requester 1 is granted.
  - The next cycle shows `rsp_valid` = 10.
- Assert `rst_n` low mid-cycle while in RESP → `rsp_valid`, `busy` and `rsp_result` go to 0 without a clock edge. After release with both valid, the first grant is to requester 0.
